cpu_subsys_bus: RTL
===================

// Module: cpu_subsys_bus
// PURPOSE
//  Bus fabric between the CPU native memory port (valid/ready) and the three subsystem slaves: ROM, RAM, peripherals.
//  Latches each request, decodes the address, and forwards a registered request to exactly one slave.
//  Returns a registered response. Unmapped accesses and stalled slaves complete with an error word and a sticky error flag.
// PARAMETERS
//  ROM_BASE       32'h0000_0000  ROM match value;  ROM_MASK    32'hFFFF_0000  ROM match mask
//  RAM_BASE       32'h0001_0000  RAM match value;  RAM_MASK    32'hFFFF_0000  RAM match mask
//  PER_BASE       32'h1000_0000  periph match value; PER_MASK  32'hF000_0000  periph match mask
//  TIMEOUT_CYCLES 255            max ACCESS cycles before error (>=1)
//  ERR_RDATA      32'hDEAD_BEEF  read data returned on error
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   async active-low reset
//  m_mem_valid    in   1   CPU request; held until m_mem_ready seen
//  m_mem_ready    out  1   one-cycle completion pulse
//  m_mem_addr     in   32  byte address
//  m_mem_wdata    in   32  write data
//  m_mem_wstrb    in   4   byte enables; 0 = read
//  m_mem_rdata    out  32  read data, valid while m_mem_ready=1
//  s_addr         out  32  latched address, broadcast to all slaves
//  s_wdata        out  32  latched write data, broadcast
//  s_wstrb        out  4   latched byte enables, broadcast
//  s_rom_valid    out  1   ROM request;   s_rom_ready in 1;  s_rom_rdata in 32
//  s_ram_valid    out  1   RAM request;   s_ram_ready in 1;  s_ram_rdata in 32
//  s_per_valid    out  1   periph request; s_per_ready in 1; s_per_rdata in 32
//  bus_err        out  1   sticky error flag
//  bus_err_addr   out  32  address of most recent error
//  bus_err_clr    in   1   clears bus_err
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; counter=0.
//   - All s_*_valid, m_mem_ready, bus_err = 0.
//   - m_mem_rdata, s_addr, s_wdata, s_wstrb, bus_err_addr = 0.
//   - Reset mid-transaction abandons it immediately; slave valid drops asynchronously.
//  Decode: slave hits when (addr & X_MASK) == X_BASE. Priority ROM > RAM > PER if windows overlap.
//  FSM states IDLE, ACCESS, RESP, ERR:
//   - IDLE: on m_mem_valid=1, latch addr/wdata/wstrb into s_*. On hit -> ACCESS with select; on miss -> ERR. counter=0.
//   - ACCESS: selected s_x_valid=1 (registered; never two slaves at once).
//     On s_x_ready=1: capture s_x_rdata, drop s_x_valid, go to RESP.
//     Otherwise counter++. If TIMEOUT_CYCLES ACCESS cycles pass with no ready, drop s_x_valid and go to ERR.
//     Ready in the last allowed cycle wins over timeout.
//   - RESP: m_mem_ready=1 for exactly one cycle, m_mem_rdata = captured data -> IDLE.
//   - ERR: m_mem_ready=1 for exactly one cycle, m_mem_rdata = ERR_RDATA. Write is dropped.
//     Set bus_err, load bus_err_addr, -> IDLE.
//  Latency: zero-wait slave gives m_mem_ready 2 cycles after the first m_mem_valid cycle; unmapped gives 1 cycle.
//  Master must drop or change the request the cycle after m_mem_ready. In IDLE, valid is only sampled then.
//  m_mem_* inputs are ignored outside IDLE. A late s_x_ready after timeout is ignored.
//  bus_err_clr clears bus_err next edge. A simultaneous new error wins: flag stays 1 and addr updates.
//  m_mem_rdata holds its last value when ready=0. s_wstrb passes through unchanged; reads carry wstrb=0.
// TESTING
//  1. ROM zero-wait read: addr 0x0000_0010, s_rom_ready tied 1, rdata 0x1234_5678.
//     -> s_rom_valid in cycle 1; m_mem_ready in cycle 2 with rdata 0x1234_5678; bus_err=0.
//  2. RAM write, 3-cycle slave delay: addr 0x0001_0004, wdata 0xA5A5_A5A5, wstrb 4'b0011.
//     -> s_ram_valid cycles 1-3, s_wstrb=0011; m_mem_ready cycle 4 only.
//  3. Unmapped read 0x2000_0000 -> m_mem_ready cycle 1, rdata 0xDEAD_BEEF.
//     -> bus_err=1, bus_err_addr=0x2000_0000; no s_*_valid ever asserted.
//  4. TIMEOUT_CYCLES=4, periph never ready, addr 0x1000_0008.
//     -> s_per_valid cycles 1-4; ERR with ready and DEAD_BEEF in cycle 5. Ready in cycle 4 instead gives normal RESP in cycle 5.
//  5. bus_err_clr pulsed alone -> bus_err 0 next cycle.
//     bus_err_clr pulsed in the same cycle as a new ERR -> bus_err stays 1, addr updated.
//  6. rst_n low during ACCESS -> s_ram_valid and m_mem_ready drop at once.
//     After release, a fresh ROM read completes per test 1.

Source files
------------

// File: rtl/cpu_subsys_bus.sv
// CPU-to-subsystem bus fabric: latches one native-port request, decodes it to ROM/RAM/peripheral,
// and returns a registered response or an error word with a sticky error flag.
module cpu_subsys_bus #(
    parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
    parameter logic [31:0] ROM_MASK       = 32'hFFFF_0000,
    parameter logic [31:0] RAM_BASE       = 32'h0001_0000,
    parameter logic [31:0] RAM_MASK       = 32'hFFFF_0000,
    parameter logic [31:0] PER_BASE       = 32'h1000_0000,
    parameter logic [31:0] PER_MASK       = 32'hF000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_mem_valid,
    output logic        m_mem_ready,
    input  logic [31:0] m_mem_addr,
    input  logic [31:0] m_mem_wdata,
    input  logic [3:0]  m_mem_wstrb,
    output logic [31:0] m_mem_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_rom_valid,
    input  logic        s_rom_ready,
    input  logic [31:0] s_rom_rdata,
    output logic        s_ram_valid,
    input  logic        s_ram_ready,
    input  logic [31:0] s_ram_rdata,
    output logic        s_per_valid,
    input  logic        s_per_ready,
    input  logic [31:0] s_per_rdata,
    output logic        bus_err,
    output logic [31:0] bus_err_addr,
    input  logic        bus_err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [31:0]        err_addr_q, err_addr_d;

    logic [2:0]         dec_sel;
    logic               slv_ready;
    logic [31:0]        slv_rdata;

    // Fixed priority ROM > RAM > PER resolves overlapping windows.
    always_comb begin
        dec_sel = 3'b000;
        if ((m_mem_addr & ROM_MASK) == ROM_BASE)      dec_sel = 3'b001;
        else if ((m_mem_addr & RAM_MASK) == RAM_BASE) dec_sel = 3'b010;
        else if ((m_mem_addr & PER_MASK) == PER_BASE) dec_sel = 3'b100;
    end

    always_comb begin
        slv_ready = 1'b0;
        slv_rdata = 32'h0;
        if (sel_q[0]) begin
            slv_ready = s_rom_ready;
            slv_rdata = s_rom_rdata;
        end else if (sel_q[1]) begin
            slv_ready = s_ram_ready;
            slv_rdata = s_ram_rdata;
        end else if (sel_q[2]) begin
            slv_ready = s_per_ready;
            slv_rdata = s_per_rdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (bus_err_clr) err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m_mem_valid) begin
                    addr_d  = m_mem_addr;
                    wdata_d = m_mem_wdata;
                    wstrb_d = m_mem_wstrb;
                    if (dec_sel != 3'b000) begin
                        sel_d   = dec_sel;
                        state_d = ACCESS;
                    end else begin
                        rdata_d = ERR_RDATA;
                        state_d = ERR;
                    end
                end
            end
            ACCESS: begin
                // A ready in the final allowed cycle is checked before the timeout.
                if (slv_ready) begin
                    rdata_d = slv_rdata;
                    sel_d   = 3'b000;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = ERR_RDATA;
                    sel_d   = 3'b000;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            ERR: begin
                err_d      = 1'b1;
                err_addr_d = addr_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_mem_ready  = (state_q == RESP) || (state_q == ERR);
    assign m_mem_rdata  = rdata_q;
    assign s_addr       = addr_q;
    assign s_wdata      = wdata_q;
    assign s_wstrb      = wstrb_q;
    assign s_rom_valid  = sel_q[0];
    assign s_ram_valid  = sel_q[1];
    assign s_per_valid  = sel_q[2];
    assign bus_err      = err_q;
    assign bus_err_addr = err_addr_q;

endmodule
